seq_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 19 +
 rtl/restoring_div_core.sv | 60 ++++++
 rtl/seq_alu.sv | 158 +++++++++++++++
 tb/tb_seq_alu.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, ERR bit positions.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_MOD = 4'b0110;

    localparam int ERR_CARRY = 0;
    localparam int ERR_DZ    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/restoring_div_core.sv
// Restoring divider producing one quotient bit per step; shared by DIV and MOD.
// quotient/remainder show the values after the current step is applied.
module restoring_div_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    import alu_pkg::*;

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dsr_q};
        if (start) begin
            quo_d = dividend;
            rem_d = '0;
            dsr_d = divisor;
        end else if (step) begin
            // A set top bit of the trial difference means the divisor did not fit.
            if (trial[WIDTH]) begin
                rem_d = rem_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end else begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
        end
    end

    assign quotient  = quo_d;
    assign remainder = rem_d;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-pass add/sub, shift-add multiply, restoring divide/modulo.
// state | meaning: IDLE idle, outputs held | RUN iterating, BUSY=1 | FIN result valid, DONE=1
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               START,
    input  logic [WIDTH-1:0]   IN1,
    input  logic [WIDTH-1:0]   IN2,
    input  logic [3:0]         OP,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] OUT,
    output logic [1:0]         ERR
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic [1:0]         err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept;
    logic               div_op;
    logic               div_zero;
    logic               last_iter;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] diff;
    logic [WIDTH:0]     mul_acc;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;
    logic               div_step;

    always_comb begin
        accept    = (state_q != ST_RUN) && START;
        div_op    = (op_q == OP_DIV) || (op_q == OP_MOD);
        div_zero  = div_op && (b_q == '0);
        last_iter = ((op_q == OP_MUL) || (div_op && !div_zero))
                    ? (cnt_q == CNT_W'(WIDTH - 1)) : 1'b1;
        div_step  = (state_q == ST_RUN) && div_op && !div_zero;

        sum  = {1'b0, a_q} + {1'b0, b_q};
        diff = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};

        // Upper half accumulates the multiplicand; lower half shifts the multiplier out.
        mul_acc   = prod_q[0] ? ({1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q})
                              : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        prod_step = {mul_acc, prod_q[WIDTH-1:1]};

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        out_d   = out_q;
        err_d   = err_q;

        case (state_q)
            ST_RUN: begin
                cnt_d  = cnt_q + CNT_W'(1);
                prod_d = prod_step;
                if (last_iter) begin
                    state_d = ST_FIN;
                    out_d   = '0;
                    err_d   = 2'b00;
                    case (op_q)
                        OP_ADD: begin
                            out_d            = {{(WIDTH-1){1'b0}}, sum};
                            err_d[ERR_CARRY] = sum[WIDTH];
                        end
                        OP_SUB: begin
                            out_d            = diff;
                            err_d[ERR_CARRY] = (a_q < b_q);
                        end
                        OP_MUL: out_d = prod_step;
                        OP_DIV: begin
                            if (div_zero) err_d[ERR_DZ] = 1'b1;
                            else          out_d = {{WIDTH{1'b0}}, div_quo};
                        end
                        OP_MOD: begin
                            if (div_zero) err_d[ERR_DZ] = 1'b1;
                            else          out_d = {{WIDTH{1'b0}}, div_rem};
                        end
                        default: ;
                    endcase
                end
            end
            ST_FIN:  if (!START) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d = ST_RUN;
            a_d     = IN1;
            b_d     = IN2;
            op_d    = OP;
            cnt_d   = '0;
            prod_d  = {{WIDTH{1'b0}}, IN2};
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_FIN);
    end

    restoring_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept),
        .step      (div_step),
        .dividend  (IN1),
        .divisor   (IN2),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            out_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            out_q   <= out_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign OUT  = out_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: fixed vectors, corner sequences, random ops vs. arithmetic model.
module tb_seq_alu;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           START;
    logic [W-1:0]   IN1, IN2;
    logic [3:0]     OP;
    logic           BUSY, DONE;
    logic [2*W-1:0] OUT;
    logic [1:0]     ERR;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .START (START),
        .IN1   (IN1),
        .IN2   (IN2),
        .OP    (OP),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .OUT   (OUT),
        .ERR   (ERR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [3:0]     op;
        logic [2*W-1:0] eo;
        logic [1:0]     ee;
        int             el;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                                  output logic [2*W-1:0] o, output logic [1:0] e, output int l);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint r  = 0;
        e = 2'b00;
        l = 1;
        case (op)
            4'b0010: begin r = ua + ub; e[0] = (r >= (longint'(1) << W)); end
            4'b0011: begin r = ua - ub; e[0] = (ua < ub); end
            4'b0100: begin r = ua * ub; l = W; end
            4'b0101: if (ub == 0) e = 2'b10; else begin r = ua / ub; l = W; end
            4'b0110: if (ub == 0) e = 2'b10; else begin r = ua % ub; l = W; end
            default: r = 0;
        endcase
        o = r[2*W-1:0];
    endfunction

    // Starts at a negedge, returns at the negedge of the DONE cycle (i.e. in FIN).
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op, input logic [2*W-1:0] eo, input logic [1:0] ee,
                          input int el, input bit poke);
        int  cyc;
        bit  busy_ok;
        bit  got;
        IN1 = a; IN2 = b; OP = op; START = 1'b1;
        @(posedge clk);
        #1;
        START = 1'b0;
        IN1 = W'($urandom); IN2 = W'($urandom); OP = 4'($urandom);
        cyc = 0; busy_ok = 1'b1; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (DONE) got = 1'b1;
            else if (!BUSY) busy_ok = 1'b0;
            if (poke && cyc == 3) begin
                IN1 = 16'd7; IN2 = 16'd9; OP = 4'b0010; START = 1'b1;
            end
            if (poke && cyc == 4) START = 1'b0;
        end
        check({name, " done_seen"}, 64'(got), 64'd1);
        check({name, " latency"}, 64'(cyc), 64'(el + 1));
        check({name, " busy_run"}, 64'(busy_ok), 64'd1);
        check({name, " busy_fin"}, 64'(BUSY), 64'd0);
        check({name, " out"}, 64'(OUT), 64'(eo));
        check({name, " err"}, 64'(ERR), 64'(ee));
    endtask

    initial begin
        logic [2*W-1:0] mo;
        logic [1:0]     me;
        int             ml;
        int             sel;
        logic [W-1:0]   ra, rb;
        logic [3:0]     rop;
        bit             seen;

        tbl[0]  = '{16'd11,    16'd51,    4'b0010, 32'd62,         2'b00, 1};
        tbl[1]  = '{16'd11,    16'd51,    4'b0011, 32'hFFFFFFD8,   2'b01, 1};
        tbl[2]  = '{16'd62091, 16'd47411, 4'b0010, 32'h0001ABBE,   2'b01, 1};
        tbl[3]  = '{16'd62091, 16'd47411, 4'b0011, 32'd14680,      2'b00, 1};
        tbl[4]  = '{16'd62091, 16'd47411, 4'b0100, 32'd2943796401, 2'b00, W};
        tbl[5]  = '{16'd62091, 16'd47411, 4'b0101, 32'd1,          2'b00, W};
        tbl[6]  = '{16'd62091, 16'd47411, 4'b0110, 32'd14680,      2'b00, W};
        tbl[7]  = '{16'd11,    16'd0,     4'b0101, 32'd0,          2'b10, 1};
        tbl[8]  = '{16'd11,    16'd0,     4'b0110, 32'd0,          2'b10, 1};
        tbl[9]  = '{16'd11,    16'd51,    4'b1111, 32'd0,          2'b00, 1};
        tbl[10] = '{16'hFFFF,  16'hFFFF,  4'b0100, 32'hFFFE0001,   2'b00, W};

        rst = 1'b1; START = 1'b0; IN1 = '0; IN2 = '0; OP = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(BUSY), 64'd0);
        check("reset done", 64'(DONE), 64'd0);
        check("reset out", 64'(OUT), 64'd0);
        check("reset err", 64'(ERR), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Consecutive entries start in the FIN cycle of the previous one.
        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op,
                   tbl[i].eo, tbl[i].ee, tbl[i].el, 1'b0);

        repeat (5) @(negedge clk);
        check("hold done", 64'(DONE), 64'd0);
        check("hold out", 64'(OUT), 64'hFFFE0001);

        run_op("mul_poke", 16'd62091, 16'd47411, 4'b0100, 32'd2943796401, 2'b00, W, 1'b1);
        @(negedge clk);
        check("after_poke idle", 64'(BUSY), 64'd0);

        IN1 = 16'd62091; IN2 = 16'd47411; OP = 4'b0100; START = 1'b1;
        @(posedge clk);
        #1;
        START = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort busy", 64'(BUSY), 64'd0);
        check("abort done", 64'(DONE), 64'd0);
        check("abort out", 64'(OUT), 64'd0);
        check("abort err", 64'(ERR), 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (DONE) seen = 1'b1;
        end
        check("abort no_done", 64'(seen), 64'd0);

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 6));
            ra  = W'($urandom);
            rb  = W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 15));
            if (sel <= 4)      rop = 4'(sel + 2);
            else if (sel == 5) rop = 4'($urandom_range(7, 15));
            else begin
                rop = 4'($urandom_range(5, 6));
                rb  = '0;
            end
            model(ra, rb, rop, mo, me, ml);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op($sformatf("rnd%0d op%0h", i, rop), ra, rb, rop, mo, me, ml, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
